// File: rtl/matrix_fifo_pkg.sv
// Shared definitions for the FIFO push buffer: buffer occupancy states and
// the width helper used to size the line counter.
package matrix_fifo_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    // Smallest bit count able to index 0..value-1 (value >= 2).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/matrix_fifo_skid2.sv
// Two-entry in-order buffer (head + skid) between the pixel source and the
// FIFO write port; head is always the word currently offered downstream.
module matrix_fifo_skid2
    import matrix_fifo_pkg::*;
#(
    parameter int c_DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    srst,
    input  logic                    clr,
    input  logic                    accept,
    input  logic                    push,
    input  logic [c_DATA_WIDTH-1:0] in_data,
    output logic [c_DATA_WIDTH-1:0] head,
    output logic                    occupied,
    output logic                    full_next
);

    state_t                  state_reg;
    state_t                  state_next;
    logic [c_DATA_WIDTH-1:0] head_reg;
    logic [c_DATA_WIDTH-1:0] head_next;
    logic [c_DATA_WIDTH-1:0] skid_reg;
    logic [c_DATA_WIDTH-1:0] skid_next;

    always_comb begin
        state_next = state_reg;
        head_next  = head_reg;
        skid_next  = skid_reg;
        case (state_reg)
            EMPTY: begin
                if (accept) begin
                    head_next  = in_data;
                    state_next = ONE;
                end
            end
            ONE: begin
                if (accept && push) begin
                    head_next = in_data;
                end else if (accept) begin
                    skid_next  = in_data;
                    state_next = TWO;
                end else if (push) begin
                    state_next = EMPTY;
                end
            end
            TWO: begin
                // No accept possible here: the ready flop was cleared on entry.
                if (push) begin
                    head_next  = skid_reg;
                    state_next = ONE;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg <= EMPTY;
            head_reg  <= '0;
            skid_reg  <= '0;
        end else if (clr) begin
            state_reg <= EMPTY;
        end else begin
            state_reg <= state_next;
            head_reg  <= head_next;
            skid_reg  <= skid_next;
        end
    end

    assign head      = head_reg;
    assign occupied  = (state_reg != EMPTY);
    assign full_next = (state_next == TWO);

endmodule

// File: rtl/matrix_fifo_push_buf.sv
// Pixel-stream front end for a FIFO write port: registered-ready skid buffer,
// per-line word counter and end-of-line pulse, with synchronous flush.
module matrix_fifo_push_buf
    import matrix_fifo_pkg::*;
#(
    parameter int c_DATA_WIDTH = 32,
    parameter int c_LINE_LEN   = 640
) (
    input  logic                            wr_clk,
    input  logic                            wr_rst,
    input  logic [c_DATA_WIDTH-1:0]         in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            in_flush,
    output logic [c_DATA_WIDTH-1:0]         wr_data,
    output logic                            wr_en,
    input  logic                            wr_vld,
    output logic [clog2(c_LINE_LEN)-1:0]    line_cnt,
    output logic                            line_done
);

    localparam int                 c_CNT_W = clog2(c_LINE_LEN);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(c_LINE_LEN - 1);

    logic               accept;
    logic               push;
    logic               full_next;
    logic               in_ready_reg;
    logic               in_ready_next;
    logic [c_CNT_W-1:0] line_cnt_reg;
    logic [c_CNT_W-1:0] line_cnt_next;
    logic               line_done_reg;
    logic               line_done_next;

    assign accept = in_valid & in_ready_reg;
    assign push   = wr_en & wr_vld;

    matrix_fifo_skid2 #(
        .c_DATA_WIDTH (c_DATA_WIDTH)
    ) u_skid2 (
        .clk       (wr_clk),
        .srst      (wr_rst),
        .clr       (in_flush),
        .accept    (accept),
        .push      (push),
        .in_data   (in_data),
        .head      (wr_data),
        .occupied  (wr_en),
        .full_next (full_next)
    );

    always_comb begin
        line_cnt_next  = line_cnt_reg;
        line_done_next = 1'b0;
        if (push) begin
            if (line_cnt_reg == c_LAST) begin
                line_cnt_next  = '0;
                line_done_next = 1'b1;
            end else begin
                line_cnt_next = line_cnt_reg + 1'b1;
            end
        end
        // A flush still lets the FIFO take its word, but the line restarts.
        if (in_flush) begin
            line_cnt_next  = '0;
            line_done_next = 1'b0;
        end
        in_ready_next = ~in_flush & ~full_next;
    end

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            in_ready_reg  <= 1'b0;
            line_cnt_reg  <= '0;
            line_done_reg <= 1'b0;
        end else begin
            in_ready_reg  <= in_ready_next;
            line_cnt_reg  <= line_cnt_next;
            line_done_reg <= line_done_next;
        end
    end

    assign in_ready  = in_ready_reg;
    assign line_cnt  = line_cnt_reg;
    assign line_done = line_done_reg;

endmodule

// File: tb/tb_matrix_fifo_push_buf.sv
// Directed + random checks of the FIFO push buffer; accepted words feed a
// scoreboard queue that a separate monitor drains on every FIFO write.
module tb_matrix_fifo_push_buf;
    import matrix_fifo_pkg::*;

    localparam int DW = 16;
    localparam int LL = 4;

    logic                 wr_clk = 1'b0;
    logic                 wr_rst;
    logic [DW-1:0]        in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_flush;
    logic [DW-1:0]        wr_data;
    logic                 wr_en;
    logic                 wr_vld;
    logic [clog2(LL)-1:0] line_cnt;
    logic                 line_done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] exp_q[$];
    logic          acc_pend = 1'b0;
    logic [DW-1:0] acc_word;
    logic          hold_pend = 1'b0;
    logic [DW-1:0] hold_data;

    matrix_fifo_push_buf #(
        .c_DATA_WIDTH (DW),
        .c_LINE_LEN   (LL)
    ) dut (
        .wr_clk    (wr_clk),
        .wr_rst    (wr_rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_flush  (in_flush),
        .wr_data   (wr_data),
        .wr_en     (wr_en),
        .wr_vld    (wr_vld),
        .line_cnt  (line_cnt),
        .line_done (line_done)
    );

    always #5 wr_clk = ~wr_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h at %0t", name, act, $time);
        end
    endtask

    // Record accepts away from the edge, commit them at the edge itself.
    always @(negedge wr_clk) begin
        if (!wr_rst && !in_flush && in_valid && in_ready) begin
            acc_pend = 1'b1;
            acc_word = in_data;
        end
    end

    always @(posedge wr_clk) begin
        if (wr_rst || in_flush) begin
            exp_q.delete();
        end else if (acc_pend) begin
            exp_q.push_back(acc_word);
        end
        acc_pend = 1'b0;
    end

    // Monitor: every FIFO write must match the oldest outstanding word.
    always @(negedge wr_clk) begin
        logic [DW-1:0] e;
        if (hold_pend) begin
            check("hold_en", 32'(wr_en), 32'd1);
            check("hold_data", 32'(wr_data), 32'(hold_data));
        end
        if (wr_en === 1'b1 && wr_vld === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("sb_spurious_write", 32'(wr_data), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("sb_data", 32'(wr_data), 32'(e));
            end
        end
        hold_pend = (wr_en === 1'b1) && !wr_vld && !wr_rst && !in_flush;
        hold_data = wr_data;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge wr_clk);
        #1;
    endtask

    initial begin
        int idx;
        int p;
        wr_rst   = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_flush = 1'b0;
        wr_vld   = 1'b0;
        repeat (3) @(posedge wr_clk);
        #1;

        // Reset state
        @(negedge wr_clk);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_line_cnt", 32'(line_cnt), 32'd0);
        check("rst_line_done", 32'(line_done), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        next_cycle();
        wr_rst = 1'b0;
        @(negedge wr_clk);
        check("rel_ready_low", 32'(in_ready), 32'd0);
        next_cycle();
        @(negedge wr_clk);
        check("rel_ready_rise", 32'(in_ready), 32'd1);
        next_cycle();

        // Back-to-back stream of 9 words, line length 4
        wr_vld = 1'b1;
        for (int j = 1; j <= 11; j++) begin
            in_valid = (j <= 9);
            in_data  = DW'(j);
            @(negedge wr_clk);
            if (j == 1) begin
                check("a_first_idle", 32'(wr_en), 32'd0);
            end else if (j <= 10) begin
                check("a_wr_en", 32'(wr_en), 32'd1);
                check("a_wr_data", 32'(wr_data), 32'(j - 1));
            end else begin
                check("a_drained", 32'(wr_en), 32'd0);
            end
            if (j >= 2) begin
                p = j - 2;
                check("a_line_cnt", 32'(line_cnt), 32'(p % 4));
                check("a_line_done", 32'(line_done), 32'((p > 0) && (p % 4 == 0)));
            end
            next_cycle();
        end

        // Backpressure: wr_vld low for cycles 3..6
        idx = 0;
        for (int s = 1; s <= 20; s++) begin
            wr_vld   = !(s >= 3 && s <= 6);
            in_valid = (idx < 6);
            in_data  = DW'(16'h11 + idx);
            @(negedge wr_clk);
            if (s == 3) check("b_ready_before_full", 32'(in_ready), 32'd1);
            if (s >= 4 && s <= 6) begin
                check("b_ready_low", 32'(in_ready), 32'd0);
                check("b_head_held", 32'(wr_data), 32'h12);
            end
            if (in_valid && in_ready) idx++;
            next_cycle();
        end
        in_valid = 1'b0;
        check("b_all_accepted", 32'(idx), 32'd6);
        @(negedge wr_clk);
        check("b_line_cnt", 32'(line_cnt), 32'd3);
        next_cycle();

        // Flush while holding two words with line_cnt = 2
        in_flush = 1'b1;
        next_cycle();
        in_flush = 1'b0;
        @(negedge wr_clk);
        check("c_pre_ready", 32'(in_ready), 32'd0);
        check("c_pre_cnt", 32'(line_cnt), 32'd0);
        next_cycle();
        for (int s = 1; s <= 4; s++) begin
            wr_vld   = (s <= 3);
            in_valid = 1'b1;
            in_data  = DW'(16'h20 + s);
            next_cycle();
        end
        in_valid = 1'b0;
        wr_vld   = 1'b0;
        in_flush = 1'b1;
        @(negedge wr_clk);
        check("c_two_ready", 32'(in_ready), 32'd0);
        check("c_two_cnt", 32'(line_cnt), 32'd2);
        check("c_two_head", 32'(wr_data), 32'h23);
        next_cycle();
        in_flush = 1'b0;
        @(negedge wr_clk);
        check("c_flush_wr_en", 32'(wr_en), 32'd0);
        check("c_flush_cnt", 32'(line_cnt), 32'd0);
        check("c_flush_ready", 32'(in_ready), 32'd0);
        check("c_flush_done", 32'(line_done), 32'd0);
        next_cycle();
        @(negedge wr_clk);
        check("c_ready_back", 32'(in_ready), 32'd1);
        next_cycle();

        // Reset mid-stream, then a short clean stream
        for (int s = 0; s < 3; s++) begin
            wr_vld   = (s <= 1);
            in_valid = 1'b1;
            in_data  = DW'(16'h30 + s);
            next_cycle();
        end
        in_valid = 1'b0;
        wr_vld   = 1'b0;
        wr_rst   = 1'b1;
        @(negedge wr_clk);
        check("d_pre_cnt", 32'(line_cnt), 32'd1);
        check("d_pre_wr_en", 32'(wr_en), 32'd1);
        next_cycle();
        wr_rst = 1'b0;
        @(negedge wr_clk);
        check("d_rst_wr_en", 32'(wr_en), 32'd0);
        check("d_rst_ready", 32'(in_ready), 32'd0);
        check("d_rst_cnt", 32'(line_cnt), 32'd0);
        check("d_rst_done", 32'(line_done), 32'd0);
        check("d_rst_data", 32'(wr_data), 32'd0);
        next_cycle();
        wr_vld   = 1'b1;
        in_valid = 1'b1;
        in_data  = DW'(16'hA);
        @(negedge wr_clk);
        check("d_ready", 32'(in_ready), 32'd1);
        next_cycle();
        in_data = DW'(16'hB);
        @(negedge wr_clk);
        check("d_word_a", 32'(wr_data), 32'hA);
        next_cycle();
        in_valid = 1'b0;
        @(negedge wr_clk);
        check("d_word_b", 32'(wr_data), 32'hB);
        next_cycle();
        @(negedge wr_clk);
        check("d_idle", 32'(wr_en), 32'd0);
        next_cycle();

        // Random traffic
        for (int c = 0; c < 10000; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            wr_vld   = 1'($urandom_range(0, 1));
            in_data  = DW'($urandom);
            next_cycle();
        end
        in_valid = 1'b0;
        wr_vld   = 1'b1;
        repeat (5) next_cycle();
        @(negedge wr_clk);
        check("e_queue_empty", 32'(exp_q.size()), 32'd0);
        check("e_idle", 32'(wr_en), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
